// File: rtl/disp_scan_ctrl_pkg.sv
// ============================================================================
// disp_scan_ctrl_pkg : shared types and constants for the 4-digit scan driver
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_scan_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned PAT_W      = NUM_DIGITS * SEG_W;

  localparam logic [SEG_W-1:0]      BLANK_SEG = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] BLANK_AN  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Active-low anode word selecting a single digit.
  function automatic logic [NUM_DIGITS-1:0] an_onehot(input logic [1:0] idx);
    an_onehot = ~(4'b0001 << idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_scan_ctrl_m4_1x7.sv
// ============================================================================
// m4_1x7 : combinational 4:1 selector of 7-bit segment patterns
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module m4_1x7
  import disp_scan_ctrl_pkg::*;
(
  input  logic [1:0]  sel_i,
  input  logic [27:0] pat_i,
  output logic [6:0]  y_o
);

  always_comb begin
    y_o = BLANK_SEG;
    case (sel_i)
      2'd0:    y_o = pat_i[0*SEG_W +: SEG_W];
      2'd1:    y_o = pat_i[1*SEG_W +: SEG_W];
      2'd2:    y_o = pat_i[2*SEG_W +: SEG_W];
      2'd3:    y_o = pat_i[3*SEG_W +: SEG_W];
      default: y_o = BLANK_SEG;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
// ============================================================================
// disp_scan_ctrl : multiplexed 4-digit 7-segment scanner with shadow buffer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 16,
  parameter int unsigned GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [27:0] pat_in,
  input  logic [3:0]  digit_mask,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick,
  output logic        upd_done
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] GAP_LAST = (GAP == 0) ? 16'd0 : 16'(GAP - 1);

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [PAT_W-1:0]        shadow_q, shadow_d;
  logic [PAT_W-1:0]        active_q, active_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    frame_tick_q, upd_done_q;

  logic                    slot_end;
  logic                    entry;
  logic                    frame_end;
  logic                    xfer;
  logic [SEG_W-1:0]        sel_pat;

  m4_1x7 u_sel (
    .sel_i (idx_q),
    .pat_i (active_q),
    .y_o   (sel_pat)
  );

  // Sequencing: slot_end marks the last cycle of a digit's slot.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    slot_end = 1'b0;
    entry    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = 2'd0;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DRIVE;
          idx_d   = 2'd0;
          cnt_d   = 16'd0;
          entry   = 1'b1;
        end
        ST_DRIVE: begin
          if (cnt_q == DIV_LAST) begin
            cnt_d = 16'd0;
            if (GAP == 0) begin
              idx_d    = idx_q + 2'd1;
              slot_end = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d  = ST_DRIVE;
            cnt_d    = 16'd0;
            idx_d    = idx_q + 2'd1;
            slot_end = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  assign frame_end = slot_end && (idx_q == 2'd3);
  assign xfer      = (frame_end || entry) && pending_q;

  // Transfer reads the old shadow; a coincident load re-arms pending.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (xfer) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = pat_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    an_d  = BLANK_AN;
    seg_d = BLANK_SEG;
    if (en && (state_q == ST_DRIVE)) begin
      seg_d = ~sel_pat;
      if (digit_mask[idx_q]) begin
        an_d = an_onehot(idx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 16'd0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      an_q         <= BLANK_AN;
      seg_q        <= BLANK_SEG;
      frame_tick_q <= 1'b0;
      upd_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_end;
      upd_done_q   <= xfer;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;
  assign upd_done   = upd_done_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
// ============================================================================
// tb_disp_scan_ctrl : directed self-checking bench for disp_scan_ctrl
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [27:0] pat_in;
  logic [3:0]  digit_mask;
  logic [6:0]  seg, seg2;
  logic [3:0]  an, an2;
  logic        ft, ft2, ud, ud2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.DIV(4), .GAP(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .pat_in     (pat_in),
    .digit_mask (digit_mask),
    .seg        (seg),
    .an         (an),
    .frame_tick (ft),
    .upd_done   (ud)
  );

  disp_scan_ctrl #(.DIV(1), .GAP(0)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .pat_in     (pat_in),
    .digit_mask (digit_mask),
    .seg        (seg2),
    .an         (an2),
    .frame_tick (ft2),
    .upd_done   (ud2)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [27:0] act;
    int          lk_a;
    logic [27:0] lp_a;
    int          lk_b;
    logic [27:0] lp_b;
    logic        ud_end;
  } frame_vec_t;

  frame_vec_t fv [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  initial begin
    logic [27:0] p0, p1, p2, p3;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    int          d;
    logic        drv;

    p0 = 28'h0FFFFFF;
    p1 = 28'h1234567;
    p2 = 28'h5A5A5A5;
    p3 = 28'h0C3F00F;

    // mask, active patterns shown, loads (cycle, value), upd_done at frame end
    fv[0] = '{4'hF, p0, -1, 28'h0, -1, 28'h0, 1'b0};
    fv[1] = '{4'hF, p0,  6, p1,    -1, 28'h0, 1'b1};
    fv[2] = '{4'hF, p1, 19, p2,    -1, 28'h0, 1'b0};
    fv[3] = '{4'hA, p1, -1, 28'h0, -1, 28'h0, 1'b1};
    fv[4] = '{4'hF, p2,  6, p3,    19, p0,    1'b1};
    fv[5] = '{4'hF, p3, -1, 28'h0, -1, 28'h0, 1'b1};
    fv[6] = '{4'h5, p0, -1, 28'h0, -1, 28'h0, 1'b0};

    rst = 1'b1; en = 1'b0; load = 1'b0; pat_in = '0; digit_mask = 4'hF;
    repeat (3) step();
    chk("rst an",  {28'h0, an},  32'hF);
    chk("rst seg", {25'h0, seg}, 32'h7F);
    chk("rst ft",  {31'h0, ft},  32'h0);
    chk("rst ud",  {31'h0, ud},  32'h0);

    rst = 1'b0; load = 1'b1; pat_in = p0;
    step();
    chk("idle an", {28'h0, an}, 32'hF);
    chk("idle ud", {31'h0, ud}, 32'h0);
    load = 1'b0; en = 1'b1;
    step();
    chk("entry ud", {31'h0, ud}, 32'h1);
    chk("entry an", {28'h0, an}, 32'hF);
    chk("entry ft", {31'h0, ft}, 32'h0);

    for (int f = 0; f < 7; f++) begin
      for (int k = 0; k < 20; k++) begin
        digit_mask = fv[f].mask;
        load       = (k == fv[f].lk_a) || (k == fv[f].lk_b);
        pat_in     = (k == fv[f].lk_b) ? fv[f].lp_b : fv[f].lp_a;
        step();
        d   = k / 5;
        drv = (k % 5) != 4;
        exp_an = 4'hF;
        if (drv && fv[f].mask[d]) exp_an[d] = 1'b0;
        exp_seg = drv ? ~fv[f].act[d*7 +: 7] : 7'h7F;
        chk($sformatf("an f%0d k%0d", f, k),  {28'h0, an},  {28'h0, exp_an});
        chk($sformatf("seg f%0d k%0d", f, k), {25'h0, seg}, {25'h0, exp_seg});
        chk($sformatf("ft f%0d k%0d", f, k),  {31'h0, ft},  {31'h0, (k == 19)});
        chk($sformatf("ud f%0d k%0d", f, k),  {31'h0, ud},  {31'h0, (k == 19) && fv[f].ud_end});
      end
    end
    load = 1'b0; digit_mask = 4'hF;

    // Enable drop during digit 2 with a pending update outstanding.
    load = 1'b1; pat_in = p1;
    step();
    load = 1'b0;
    repeat (10) step();
    chk("pre-drop an", {28'h0, an}, 32'hB);
    en = 1'b0;
    step();
    chk("drop an", {28'h0, an},  32'hF);
    chk("drop seg", {25'h0, seg}, 32'h7F);
    chk("drop ud", {31'h0, ud},  32'h0);
    step();
    step();
    chk("idle2 an", {28'h0, an}, 32'hF);
    chk("idle2 ft", {31'h0, ft}, 32'h0);
    en = 1'b1;
    step();
    chk("re-entry ud", {31'h0, ud}, 32'h1);
    chk("re-entry an", {28'h0, an}, 32'hF);
    step();
    chk("restart an", {28'h0, an}, 32'hE);
    chk("restart seg", {25'h0, seg}, {25'h0, ~p1[6:0]});

    // Reset on the edge that would otherwise raise frame_tick.
    repeat (18) step();
    rst = 1'b1;
    step();
    chk("midrst an",  {28'h0, an},  32'hF);
    chk("midrst seg", {25'h0, seg}, 32'h7F);
    chk("midrst ft",  {31'h0, ft},  32'h0);
    chk("midrst ud",  {31'h0, ud},  32'h0);
    chk("midrst an2", {28'h0, an2}, 32'hF);
    step();
    chk("midrst ft hold", {31'h0, ft}, 32'h0);

    rst = 1'b0;
    step();
    chk("post-rst ud", {31'h0, ud}, 32'h0);
    chk("post-rst an", {28'h0, an}, 32'hF);
    chk("post-rst an2", {28'h0, an2}, 32'hF);
    for (int s = 1; s <= 12; s++) begin
      step();
      exp_an = 4'hF;
      exp_an[(s - 1) % 4] = 1'b0;
      chk($sformatf("fast an s%0d", s), {28'h0, an2}, {28'h0, exp_an});
      chk($sformatf("fast ft s%0d", s), {31'h0, ft2}, {31'h0, ((s - 1) % 4) == 3});
      if (s == 1) begin
        chk("post-rst an d0", {28'h0, an}, 32'hE);
        chk("post-rst seg cleared", {25'h0, seg}, 32'h7F);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter DIV, default 16: clock cycles each digit is driven per slot; legal range 1..65535.
REQ-002 Parameter GAP, default 2: blanking cycles after each digit slot; legal range 0..255; 0 removes the gap.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  scan enable; 0 holds the block blank in IDLE.
REQ-006 load  input  1  one-cycle request to capture pat_in into the shadow buffer.
REQ-007 pat_in  input  28  new patterns, active-high segments; [6:0] digit 0 … [27:21] digit 3.
REQ-008 digit_mask  input  4  per-digit enable; 0 forces that digit's anode off during its slot.
REQ-009 seg  output  7  segment drive, active-low, registered.
REQ-010 an  output  4  anode drive, active-low, one-hot-low or all-high, registered.
REQ-011 frame_tick  output  1  one-cycle pulse at end of each full 4-digit frame.
REQ-012 upd_done  output  1  one-cycle pulse when shadow data is transferred to the active buffer.

Function
REQ-013 The block SHALL implement states IDLE, DRIVE, GAP with a 2-bit digit index (0..3) and a slot counter.
REQ-014 IDLE: an=4'b1111, seg=7'b1111111; when en=1, transition to DRIVE on digit 0 with counter cleared.
REQ-015 DRIVE: an bit[idx]=0 if digit_mask[idx]=1, otherwise an=4'b1111; seg=~active[idx]; lasts exactly DIV cycles.
REQ-016 After DRIVE, transition to GAP (an=4'b1111, seg=7'b1111111) for exactly GAP cycles; if GAP=0, go directly to the next DRIVE.
REQ-017 On leaving a digit's slot, idx SHALL increment modulo 4; wrap 3->0 marks the frame boundary.
REQ-018 frame_tick SHALL pulse on the cycle the last slot cycle of digit 3 is presented (DRIVE end if GAP=0, else GAP end).
REQ-019 load=1 SHALL write pat_in into the shadow buffer and set pending; a later load before transfer overwrites the shadow.
REQ-020 Transfer shadow->active SHALL occur only at a frame boundary or on IDLE->DRIVE entry, when pending=1; it clears pending and pulses upd_done in the same cycle.
REQ-021 Transfer SHALL use shadow contents from before the current edge; load coincident with a boundary is held pending until the next boundary.
REQ-022 digit_mask SHALL be sampled every cycle; changes affect an immediately but never alter slot timing.
REQ-023 en=0 in any state SHALL enter IDLE next cycle, clear idx and counter, and retain shadow and pending.
REQ-024 Output latency: an/seg reflect the state one cycle after the state/idx update (registered outputs).

Reset
REQ-025 rst=1 SHALL force IDLE, idx=0, counter=0, pending=0, shadow=0, active=0, an=4'b1111, seg=7'b1111111, frame_tick=0, upd_done=0.
REQ-026 rst SHALL take priority over en and load in the same cycle; reset mid-frame aborts the frame with no frame_tick.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, DRIVE, GAP), NUM_DIGITS=4, SEG_W=7, and the BLANK_SEG/BLANK_AN constants.
REQ-028 One sub-module m4_1x7 (4:1 selector of 7-bit patterns, combinational) SHALL select active[idx]; all sequencing stays in disp_scan_ctrl.

Verification (DIV=4, GAP=1 unless noted)
REQ-029 rst, en=1, load pat_in=28'h0FFFFFF -> upd_done on DRIVE entry; an cycles 1110,1111,1101,1111,1011,1111,0111,1111 with 4/1-cycle widths; frame_tick every 20 cycles.
REQ-030 Mid-frame load pat_in=28'h1234567 during digit 1 -> active unchanged until digit 3 GAP end; upd_done and frame_tick coincide; next frame shows new patterns.
REQ-031 load asserted exactly on frame_tick cycle -> that value transferred one frame (20 cycles) later, not immediately.
REQ-032 digit_mask=4'b1010 -> an never drives digits 0 or 2 low; frame_tick period stays 20 cycles.
REQ-033 GAP=0, DIV=1 -> an steps 1110,1101,1011,0111 every cycle, frame_tick every 4 cycles.
REQ-034 en dropped during digit 2 then raised 3 cycles later -> an=1111 next cycle, pending retained, scan restarts at digit 0; rst mid-frame -> all outputs at reset values next cycle.
